// File: rtl/fixed_decoder_pkg.sv
// Shared types and constants for the multi-channel fixed-predictor decoder.
// Holds the FSM state enum, order encodings and the prediction width helper.
package fixed_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_ORDER = 4;

  localparam logic [2:0] ORD0 = 3'd0;
  localparam logic [2:0] ORD1 = 3'd1;
  localparam logic [2:0] ORD2 = 3'd2;
  localparam logic [2:0] ORD3 = 3'd3;
  localparam logic [2:0] ORD4 = 3'd4;

  // Headroom for 4h1-6h2+4h3-h4 plus the residual.
  function automatic int pred_w(input int data_w);
    return data_w + 4;
  endfunction

endpackage

// File: rtl/fixed_predictor.sv
// Combinational fixed-order predictor: residual + prediction from h1..h4.
// Ports: order, h1..h4 (most recent first), res in; sample out, wrapped to DATA_W.
module fixed_predictor
  import fixed_decoder_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]               order,
  input  logic signed [DATA_W-1:0] h1,
  input  logic signed [DATA_W-1:0] h2,
  input  logic signed [DATA_W-1:0] h3,
  input  logic signed [DATA_W-1:0] h4,
  input  logic signed [DATA_W-1:0] res,
  output logic signed [DATA_W-1:0] sample
);

  localparam int PW = pred_w(DATA_W);

  logic signed [PW-1:0] e1, e2, e3, e4, er;
  logic signed [PW-1:0] pred;

  assign e1 = {{4{h1[DATA_W-1]}}, h1};
  assign e2 = {{4{h2[DATA_W-1]}}, h2};
  assign e3 = {{4{h3[DATA_W-1]}}, h3};
  assign e4 = {{4{h4[DATA_W-1]}}, h4};
  assign er = {{4{res[DATA_W-1]}}, res};

  always_comb begin
    pred = '0;
    case (order)
      ORD1: pred = e1;
      ORD2: pred = (e1 <<< 1) - e2;
      ORD3: pred = (e1 <<< 1) + e1
                 - (e2 <<< 1) - e2 + e3;
      ORD4: pred = (e1 <<< 2)
                 - (e2 <<< 2) - (e2 <<< 1)
                 + (e3 <<< 2) - e4;
      // Orders 0 and 5..7 predict zero.
      default: pred = '0;
    endcase
  end

  // Two's-complement wrap, no saturation.
  assign sample = DATA_W'(pred + er);

endmodule

// File: rtl/fixed_predictor_decoder_mc.sv
// Multi-channel FLAC fixed-predictor decoder with valid/ready input.
// Ports: iClock/iReset, iStart/iOrder/iBlockSize, iValid/oReady/iSample, oData/oValid/oChannel/oDone.
module fixed_predictor_decoder_mc
  import fixed_decoder_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 2,
  parameter int BS_W     = 16,
  localparam int CH_W = $clog2(CHANNELS > 2 ? CHANNELS : 2)
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iStart,
  input  logic [3*CHANNELS-1:0]     iOrder,
  input  logic [BS_W-1:0]           iBlockSize,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic signed [DATA_W-1:0]  iSample,
  output logic signed [DATA_W-1:0]  oData,
  output logic                      oValid,
  output logic [CH_W-1:0]           oChannel,
  output logic                      oDone
);

  // Banks padded to a power of two so ch_q indexes them exactly.
  localparam int NB = 1 << CH_W;

  state_t                   state;
  logic [3*NB-1:0]          ord_q;
  logic [BS_W-1:0]          bs_q;
  logic [BS_W-1:0]          idx_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] hist [NB][4];

  logic [2:0]               ord_act;
  logic [2:0]               ord_eff;
  logic                     warm;
  logic                     last;
  logic signed [DATA_W-1:0] pred_s;
  logic signed [DATA_W-1:0] out_s;

  assign oReady  = (state == RUN);
  assign ord_act = ord_q[3*ch_q +: 3];
  assign ord_eff = (ord_act > ORD4) ? ORD0 : ord_act;
  assign warm    = idx_q < BS_W'(ord_eff);
  assign last    = (ch_q == CH_W'(CHANNELS - 1))
                && (idx_q == bs_q - BS_W'(1));
  assign out_s   = warm ? iSample : pred_s;

  fixed_predictor #(
    .DATA_W (DATA_W)
  ) u_pred (
    .order  (ord_eff),
    .h1     (hist[ch_q][0]),
    .h2     (hist[ch_q][1]),
    .h3     (hist[ch_q][2]),
    .h4     (hist[ch_q][3]),
    .res    (iSample),
    .sample (pred_s)
  );

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state    <= IDLE;
      ord_q    <= '0;
      bs_q     <= '0;
      idx_q    <= '0;
      ch_q     <= '0;
      oData    <= '0;
      oValid   <= 1'b0;
      oChannel <= '0;
      oDone    <= 1'b0;
      for (int c = 0; c < NB; c++)
        for (int k = 0; k < 4; k++)
          hist[c][k] <= '0;
    end else begin
      oValid <= 1'b0;
      oDone  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iStart) begin
            ord_q <= (3*NB)'(iOrder);
            bs_q  <= iBlockSize;
            idx_q <= '0;
            ch_q  <= '0;
            for (int c = 0; c < NB; c++)
              for (int k = 0; k < 4; k++)
                hist[c][k] <= '0;
            state <= (iBlockSize == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (iValid) begin
            oData         <= out_s;
            oValid        <= 1'b1;
            oChannel      <= ch_q;
            hist[ch_q][0] <= out_s;
            hist[ch_q][1] <= hist[ch_q][0];
            hist[ch_q][2] <= hist[ch_q][1];
            hist[ch_q][3] <= hist[ch_q][2];
            if (last) begin
              state <= DONE;
            end else if (ch_q == CH_W'(CHANNELS - 1)) begin
              ch_q  <= '0;
              idx_q <= idx_q + BS_W'(1);
            end else begin
              ch_q <= ch_q + CH_W'(1);
            end
          end
        end
        DONE: begin
          oDone <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_predictor_decoder_mc.sv
// Testbench for fixed_predictor_decoder_mc: directed table on a 16-bit
// mono instance, randomized blocks on a 32-bit stereo instance.
module tb_fixed_predictor_decoder_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A: DATA_W=16, CHANNELS=1
  logic        a_start = 1'b0;
  logic [2:0]  a_order = '0;
  logic [15:0] a_bs = '0;
  logic        a_valid = 1'b0;
  logic [15:0] a_sample = '0;
  logic        a_ready, a_vo, a_done;
  logic [15:0] a_data;
  logic [0:0]  a_ch;

  // Instance B: DATA_W=32, CHANNELS=2
  logic        b_start = 1'b0;
  logic [5:0]  b_order = '0;
  logic [15:0] b_bs = '0;
  logic        b_valid = 1'b0;
  logic [31:0] b_sample = '0;
  logic        b_ready, b_vo, b_done;
  logic [31:0] b_data;
  logic [0:0]  b_ch;

  fixed_predictor_decoder_mc #(
    .DATA_W(16), .CHANNELS(1), .BS_W(16)
  ) dut_a (
    .iClock(clk), .iReset(rst),
    .iStart(a_start), .iOrder(a_order),
    .iBlockSize(a_bs), .iValid(a_valid),
    .oReady(a_ready), .iSample(a_sample),
    .oData(a_data), .oValid(a_vo),
    .oChannel(a_ch), .oDone(a_done)
  );

  fixed_predictor_decoder_mc #(
    .DATA_W(32), .CHANNELS(2), .BS_W(16)
  ) dut_b (
    .iClock(clk), .iReset(rst),
    .iStart(b_start), .iOrder(b_order),
    .iBlockSize(b_bs), .iValid(b_valid),
    .oReady(b_ready), .iSample(b_sample),
    .oData(b_data), .oValid(b_vo),
    .oChannel(b_ch), .oDone(b_done)
  );

  int aq_d[$], aq_c[$], aq_ch[$];
  int ad_n = 0, ad_c = 0;
  int bq_d[$], bq_ch[$];
  int bd_n = 0;

  always @(negedge clk) begin
    if (a_vo) begin
      aq_d.push_back(int'($signed(a_data)));
      aq_c.push_back(cyc);
      aq_ch.push_back(int'(a_ch));
    end
    if (a_done) begin
      ad_n++;
      ad_c = cyc;
    end
    if (b_vo) begin
      bq_d.push_back(int'($signed(b_data)));
      bq_ch.push_back(int'(b_ch));
    end
    if (b_done) bd_n++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    string name;
    int    ord;
    int    bs;
    bit    gap;
    int    in[4];
    int    exp[4];
  } vec_t;

  function automatic vec_t mk(input string nm, input int ord,
    input int bs, input bit gap,
    input int i0, input int i1, input int i2, input int i3,
    input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.name = nm; v.ord = ord; v.bs = bs; v.gap = gap;
    v.in[0] = i0; v.in[1] = i1; v.in[2] = i2; v.in[3] = i3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic run_a(input vec_t v);
    int xc[$];
    int k, g, s;
    aq_d.delete(); aq_c.delete(); aq_ch.delete();
    ad_n = 0;
    @(negedge clk);
    a_start = 1'b1;
    a_order = 3'(v.ord);
    a_bs = 16'(v.bs);
    s = cyc;
    @(negedge clk);
    a_start = 1'b0;
    k = 0; g = 0;
    while (k < v.bs && g < 100) begin
      g++;
      a_valid = v.gap ? g[0] : 1'b1;
      a_sample = 16'(v.in[k]);
      if (a_valid && a_ready) begin
        xc.push_back(cyc + 1);
        k++;
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    repeat (4) @(negedge clk);
    check({v.name, " count"}, aq_d.size(), v.bs);
    for (int i = 0; i < v.bs && i < aq_d.size(); i++) begin
      check($sformatf("%s data[%0d]", v.name, i), aq_d[i], v.exp[i]);
      check($sformatf("%s chan[%0d]", v.name, i), aq_ch[i], 0);
      if (i < xc.size())
        check($sformatf("%s latency[%0d]", v.name, i), aq_c[i], xc[i]);
    end
    check({v.name, " done count"}, ad_n, 1);
    if (v.bs > 0 && aq_c.size() > 0)
      check({v.name, " done cycle"}, ad_c, aq_c[aq_c.size()-1] + 1);
    else
      check({v.name, " done cycle"}, ad_c, s + 2);
  endtask

  int coef[5][4] = '{'{0, 0, 0, 0}, '{1, 0, 0, 0}, '{2, -1, 0, 0},
                     '{3, -3, 1, 0}, '{4, -6, 4, -1}};

  task automatic run_b(input int o0, input int o1, input int bs,
                       input bit gap, input int blk);
    int inp[2][8];
    int mdl[2][8];
    int ords[2];
    int eo, j, g, c, i;
    longint p;
    ords[0] = o0; ords[1] = o1;
    for (int ii = 0; ii < bs; ii++)
      for (int cc = 0; cc < 2; cc++)
        inp[cc][ii] = int'($urandom);
    for (int cc = 0; cc < 2; cc++) begin
      eo = (ords[cc] > 4) ? 0 : ords[cc];
      for (int ii = 0; ii < bs; ii++) begin
        if (ii < eo) begin
          mdl[cc][ii] = inp[cc][ii];
        end else begin
          p = longint'(inp[cc][ii]);
          for (int t = 0; t < eo; t++)
            p += longint'(coef[eo][t]) * longint'(mdl[cc][ii-1-t]);
          mdl[cc][ii] = int'(p);
        end
      end
    end
    bq_d.delete(); bq_ch.delete();
    bd_n = 0;
    @(negedge clk);
    b_start = 1'b1;
    b_order = {3'(o1), 3'(o0)};
    b_bs = 16'(bs);
    @(negedge clk);
    b_start = 1'b0;
    j = 0; g = 0;
    while (j < 2*bs && g < 200) begin
      g++;
      c = j % 2; i = j / 2;
      b_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      b_sample = 32'(inp[c][i]);
      // Stray starts mid-block must be ignored.
      b_start = ($urandom_range(0, 3) == 0);
      b_bs = 16'($urandom);
      if (b_valid && b_ready) j++;
      @(negedge clk);
    end
    b_valid = 1'b0;
    b_start = 1'b0;
    repeat (4) @(negedge clk);
    check($sformatf("rnd%0d count", blk), bq_d.size(), 2*bs);
    for (int n = 0; n < 2*bs && n < bq_d.size(); n++) begin
      check($sformatf("rnd%0d chan[%0d]", blk, n), bq_ch[n], n % 2);
      check($sformatf("rnd%0d data[%0d]", blk, n), bq_d[n],
            mdl[n%2][n/2]);
    end
    check($sformatf("rnd%0d done count", blk), bd_n, 1);
  endtask

  vec_t tab[10];

  initial begin
    tab[0] = mk("ord0", 0, 4, 0, 10, -7, -4, 8, 10, -7, -4, 8);
    tab[1] = mk("ord1", 1, 4, 0, 10, -7, -4, 8, 10, 3, -1, 7);
    tab[2] = mk("ord2", 2, 4, 0, 10, -7, -4, 8, 10, -7, -28, -41);
    tab[3] = mk("ord3", 3, 4, 0, 10, -7, -4, 8, 10, -7, -4, 27);
    tab[4] = mk("wrap", 1, 2, 0, 32767, 1, 0, 0, 32767, -32768, 0, 0);
    tab[5] = mk("blk0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[6] = mk("ord4b2", 4, 2, 0, 10, -7, 0, 0, 10, -7, 0, 0);
    tab[7] = mk("ord4b4", 4, 4, 0, 1, 2, 3, 4, 1, 2, 3, 4);
    tab[8] = mk("ord5", 5, 3, 0, 3, 4, 5, 0, 3, 4, 5, 0);
    tab[9] = mk("ord2gap", 2, 4, 1, 10, -7, -4, 8, 10, -7, -28, -41);

    @(negedge clk);
    check("reset oValid", a_vo, 0);
    check("reset oReady", a_ready, 0);
    check("reset oDone", a_done, 0);
    check("reset oData", a_data, 0);
    check("reset oChannel", b_ch, 0);
    check("reset b oData", b_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 10; t++) run_a(tab[t]);

    // Stereo directed case.
    bq_d.delete(); bq_ch.delete(); bd_n = 0;
    begin
      int sin[6] = '{5, 1, 2, 2, -1, 3};
      int ech[6] = '{0, 1, 0, 1, 0, 1};
      int edt[6] = '{5, 1, 7, 2, 6, 3};
      @(negedge clk);
      b_start = 1'b1; b_order = {3'd0, 3'd1}; b_bs = 16'd3;
      @(negedge clk);
      b_start = 1'b0;
      for (int n = 0; n < 6; n++) begin
        b_valid = 1'b1;
        b_sample = 32'(sin[n]);
        @(negedge clk);
      end
      b_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("st count", bq_d.size(), 6);
      for (int n = 0; n < 6 && n < bq_d.size(); n++) begin
        check($sformatf("st chan[%0d]", n), bq_ch[n], ech[n]);
        check($sformatf("st data[%0d]", n), bq_d[n], edt[n]);
      end
      check("st done count", bd_n, 1);
    end

    // Reset after 2 of 4 samples.
    aq_d.delete(); aq_c.delete(); aq_ch.delete(); ad_n = 0;
    @(negedge clk);
    a_start = 1'b1; a_order = 3'd1; a_bs = 16'd4;
    @(negedge clk);
    a_start = 1'b0; a_valid = 1'b1; a_sample = 16'd10;
    @(negedge clk);
    a_sample = -16'sd7;
    @(negedge clk);
    a_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort oValid", a_vo, 0);
    check("abort oData", a_data, 0);
    check("abort oReady", a_ready, 0);
    check("abort pre count", aq_d.size(), 2);
    if (aq_d.size() == 2) begin
      check("abort pre data0", aq_d[0], 10);
      check("abort pre data1", aq_d[1], 3);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort no done", ad_n, 0);
    run_a(tab[1]);

    for (int blk = 0; blk < 12; blk++)
      run_b($urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 8), 1'($urandom_range(0, 1)), blk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
